pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready flow control. It replaces the fixed-field ID/EX-style registers with one generic stage carrying a DATA_W payload and a CTRL_W control bundle. A two-entry skid buffer keeps `in_ready` registered, so back-pressure does not form a combinational path across stages. Flush, guaranteed-zero control on bubbles and a saturating stall counter are built in. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- DATA_W, 32, payload width (operands, instruction word); no control meaning
- CTRL_W, 16, control-bit width; these bits are forced to zero whenever the stage holds no valid beat
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held beats and of the beat offered this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat; driven directly from a register
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bundle
- out_valid  out  1  beat presented downstream
- out_ready  in  1  downstream accepts the beat
- out_data  out  DATA_W  presented payload
- out_ctrl  out  CTRL_W  presented control; all zero when out_valid=0
- occupancy  out  2  number of held beats (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds data, ctrl and a valid bit.
- accept = in_valid & in_ready & !flush
- take = out_valid & out_ready
- States are encoded by occupancy:
  - EMPTY (0): accept -> ONE, main <= in.
  - ONE (1):
    - accept & take -> ONE, main <= in.
    - accept & !take -> FULL, skid <= in.
    - !accept & take -> EMPTY.
    - !accept & !take -> ONE, main unchanged.
  - FULL (2): in_ready=0, so no accept. take -> ONE, main <= skid, skid cleared. !take -> FULL, held.
- in_ready is registered: it equals 1 exactly when the next state is not FULL.
- flush has highest priority and applies in any state:
  - next state EMPTY; in_ready=1 next cycle.
  - main and skid data, ctrl and valid all cleared to zero.
  - A beat offered in the flush cycle is not accepted, even if in_ready=1.
  - A take in the flush cycle still completes; the downstream has sampled it.
- Vacated entries are cleared to zero, data included. This keeps out_ctrl and out_data zero on every bubble.
- stall_cnt: +1 every cycle with out_valid & !out_ready; holds at 2^CNT_W-1. Only rst clears it; flush does not.
- In-order: beats leave in acceptance order. No beat is duplicated or dropped unless flushed.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_ctrl=0
  - in_ready=1, occupancy=0, stall_cnt=0
  - Outputs take these values immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge N is on out_* after edge N, whether the stage was EMPTY, or in ONE with a take.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure:
  - out_ready low for one cycle in ONE with accept -> FULL; in_ready drops after that edge.
  - An upstream beat offered in the same cycle as the drop was already captured in skid, so no loss.
- Release: the first take in FULL -> ONE; in_ready=1 after that edge.
- occupancy, in_ready and out_valid all change only on clock edges or on rst assertion.
- rst asserted mid-transfer: all held beats discarded; the counter clears.

## Test plan
- Reset then stream: DATA_W=32. Release rst, hold out_ready=1, send 0x11..0x18 back-to-back. Expect out_data 0x11..0x18 on consecutive cycles one cycle later, in_ready constant 1, stall_cnt=0.
- Skid fill: send 0xA1, 0xA2, 0xA3 with out_ready=0 from the cycle 0xA1 is accepted.
  - After 0xA2 is accepted: occupancy=2, in_ready=0; 0xA3 is held off.
  - Raise out_ready: outputs 0xA1, 0xA2, 0xA3 in order; stall_cnt equals the cycles out_ready was low with out_valid=1.
- Flush in FULL: with 0xB1/0xB2 held, assert flush while in_valid=1 with 0xB3.
  - Next cycle: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
  - 0xB3 never appears; stall_cnt unchanged.
- Bubble control: CTRL_W=16. Send ctrl=0xFFFF, then in_valid=0 for 3 cycles. Expect out_ctrl=0x0000 on every cycle with out_valid=0.
- Counter saturation: CNT_W=4, hold out_ready=0 with a valid beat for 20 cycles. Expect stall_cnt stops at 15; reset returns it to 0.
- Async reset: assert rst between clock edges while occupancy=2. Expect outputs at their reset values before the next edge; first beat after release appears with latency 1.

Source files
------------

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream beat, downstream beat,
// flush and the stage's observable status (occupancy doubles as FSM state).
//
// Valid/ready contract, both sides: a beat transfers on a rising edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer; ready may change freely and never depends
// combinationally on valid. On the downstream side out_valid/out_data/out_ctrl
// are registered; on the upstream side in_ready is registered.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  // Driving side: upstream producer, downstream consumer and flush source.
  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );

  // The stage itself.
  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a two-entry skid buffer.
// The main entry drives the outputs; the skid entry catches the one beat that
// may arrive in the cycle in_ready falls, so in_ready can come from a flop.
// Empty entries are always all-zero, which makes bubbles carry zero control.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stage_skid_if.slave   bus
);

  // Occupancy encoding doubles as the state; it is exported on bus.occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] STALL_MAX = '1;
  localparam logic [CNT_W-1:0] STALL_INC = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic              main_vld_q, main_vld_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              skid_vld_q, skid_vld_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic accept;
  logic take;

  // A beat offered during flush is refused even when in_ready is high.
  assign accept = bus.in_valid & in_ready_q & ~bus.flush;
  assign take   = main_vld_q & bus.out_ready;

  // Next-state: FSM transition, entry moves/clears, registered in_ready, stall count.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    main_vld_d  = main_vld_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_vld_d  = skid_vld_q;
    stall_d     = stall_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
          main_vld_d  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && take) begin
          // Pass-through: the outgoing beat is replaced in the same edge.
          main_data_d = bus.in_data;
          main_ctrl_d = bus.in_ctrl;
          main_vld_d  = 1'b1;
        end else if (accept) begin
          state_d     = ST_FULL;
          skid_data_d = bus.in_data;
          skid_ctrl_d = bus.in_ctrl;
          skid_vld_d  = 1'b1;
        end else if (take) begin
          state_d     = ST_EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
          main_vld_d  = 1'b0;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a take can move the state.
        if (take) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          main_vld_d  = 1'b1;
          skid_data_d = '0;
          skid_ctrl_d = '0;
          skid_vld_d  = 1'b0;
        end
      end
      default: begin
        // Unreachable encoding: recover to a clean empty stage.
        state_d     = ST_EMPTY;
        main_data_d = '0;
        main_ctrl_d = '0;
        main_vld_d  = 1'b0;
        skid_data_d = '0;
        skid_ctrl_d = '0;
        skid_vld_d  = 1'b0;
      end
    endcase

    // Flush overrides everything; a take in this cycle has already been
    // sampled downstream, so discarding the main entry loses nothing.
    if (bus.flush) begin
      state_d     = ST_EMPTY;
      main_data_d = '0;
      main_ctrl_d = '0;
      main_vld_d  = 1'b0;
      skid_data_d = '0;
      skid_ctrl_d = '0;
      skid_vld_d  = 1'b0;
    end

    // Ready for the next cycle exactly when the stage will not be full.
    in_ready_d = (state_d != ST_FULL);

    // Saturating stall counter; flush does not clear it.
    if (main_vld_q && !bus.out_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_INC;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      main_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_vld_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      main_vld_q  <= main_vld_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_vld_q  <= skid_vld_d;
      in_ready_q  <= in_ready_d;
      stall_q     <= stall_d;
    end
  end

  // All outputs come straight from flops.
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_vld_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.occupancy = state_q;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenario tasks plus a negedge
// scoreboard monitor that checks order/content of every beat taken.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int BW     = DATA_W + CTRL_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] mon_got;
  logic [BW-1:0] mon_exp;

  // ---------------- scoreboard monitor ----------------
  // Inputs change at posedge+1, so the negedge sees the values for the
  // transfer happening at the next posedge.
  always @(negedge clk) begin
    if (rst) begin
      tests_run++;
      if (bus.out_valid === 1'b0 && (bus.out_ctrl !== '0 || bus.out_data !== '0)) begin
        tests_failed++;
        $display("FAIL bubble_zero: out_ctrl=%h out_data=%h want 0", bus.out_ctrl, bus.out_data);
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        mon_got = {bus.out_ctrl, bus.out_data};
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got %h with empty expected queue", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            tests_failed++;
            $display("FAIL sb_beat: got %h want %h", mon_got, mon_exp);
          end
        end
      end
      if (bus.flush === 1'b1) exp_q.delete();
      else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
        exp_q.push_back({bus.in_ctrl, bus.in_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_ctrl  = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    drive(1'b0, '0, '0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.out_data !== '0) begin tests_failed++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    tests_run++; if (bus.out_ctrl !== '0) begin tests_failed++; $display("FAIL reset_out_ctrl: got %h want 0", bus.out_ctrl); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests_run++; if (bus.occupancy !== 2'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
    tests_run++; if (bus.stall_cnt !== '0) begin tests_failed++; $display("FAIL reset_stall_cnt: got %0d want 0", bus.stall_cnt); end
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic test_stream();
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      if (i > 0 && i <= 8) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'(32'h10 + i)) begin
          tests_failed++;
          $display("FAIL stream_beat%0d: valid=%b data=%h want 1/%h", i, bus.out_valid, bus.out_data, DATA_W'(32'h10 + i));
        end
      end
      tests_run++;
      if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL stream_in_ready: got %b want 1", bus.in_ready); end
      if (i < 8) drive(1'b1, DATA_W'(32'h11 + i), CTRL_W'(16'h0100 + i));
      else drive(1'b0, '0, '0);
    end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_drained: out_valid=%b want 0", bus.out_valid); end
    tests_run++; if (bus.stall_cnt !== '0) begin tests_failed++; $display("FAIL stream_stall: got %0d want 0", bus.stall_cnt); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL stream_queue: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_skid_fill();
    do_reset();
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA1, 16'h00A1);
    tick();
    drive(1'b1, 32'hA2, 16'h00A2);
    tick();
    tests_run++; if (bus.occupancy !== 2'd2) begin tests_failed++; $display("FAIL skid_occ_full: got %0d want 2", bus.occupancy); end
    tests_run++; if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL skid_in_ready_low: got %b want 0", bus.in_ready); end
    tests_run++; if (bus.stall_cnt !== CNT_W'(1)) begin tests_failed++; $display("FAIL skid_stall1: got %0d want 1", bus.stall_cnt); end
    drive(1'b1, 32'hA3, 16'h00A3);
    for (int h = 0; h < 2; h++) begin
      tick();
      tests_run++;
      if (bus.occupancy !== 2'd2 || bus.in_ready !== 1'b0 || bus.out_data !== 32'hA1) begin
        tests_failed++;
        $display("FAIL skid_hold: occ=%0d in_ready=%b data=%h want 2/0/a1", bus.occupancy, bus.in_ready, bus.out_data);
      end
      tests_run++;
      if (bus.stall_cnt !== CNT_W'(2 + h)) begin tests_failed++; $display("FAIL skid_stall_hold: got %0d want %0d", bus.stall_cnt, 2 + h); end
    end
    bus.out_ready = 1'b1;
    tick();
    tests_run++;
    if (bus.out_data !== 32'hA2 || bus.occupancy !== 2'd1 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL skid_release: data=%h occ=%0d in_ready=%b want a2/1/1", bus.out_data, bus.occupancy, bus.in_ready);
    end
    tick();
    tests_run++; if (bus.out_data !== 32'hA3) begin tests_failed++; $display("FAIL skid_third: got %h want a3", bus.out_data); end
    drive(1'b0, '0, '0);
    tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL skid_empty: out_valid=%b want 0", bus.out_valid); end
    tests_run++; if (bus.stall_cnt !== CNT_W'(3)) begin tests_failed++; $display("FAIL skid_stall_total: got %0d want 3", bus.stall_cnt); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL skid_queue: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_flush_full();
    do_reset();
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hB1, 16'h00B1);
    tick();
    drive(1'b1, 32'hB2, 16'h00B2);
    tick();
    tests_run++; if (bus.occupancy !== 2'd2) begin tests_failed++; $display("FAIL flush_pre_occ: got %0d want 2", bus.occupancy); end
    // B1 is taken in the flush cycle; B2 and the offered B3 are killed.
    drive(1'b1, 32'hB3, 16'h00B3);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, '0, '0);
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
    tests_run++; if (bus.out_ctrl !== '0 || bus.out_data !== '0) begin tests_failed++; $display("FAIL flush_zero: ctrl=%h data=%h want 0", bus.out_ctrl, bus.out_data); end
    tests_run++; if (bus.occupancy !== 2'd0) begin tests_failed++; $display("FAIL flush_occ: got %0d want 0", bus.occupancy); end
    tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    tests_run++; if (bus.stall_cnt !== CNT_W'(1)) begin tests_failed++; $display("FAIL flush_stall: got %0d want 1", bus.stall_cnt); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.stall_cnt !== CNT_W'(1)) begin
        tests_failed++;
        $display("FAIL flush_after: out_valid=%b stall=%0d want 0/1", bus.out_valid, bus.stall_cnt);
      end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL flush_queue: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_bubble();
    do_reset();
    bus.out_ready = 1'b1;
    tick();
    drive(1'b1, 32'hC0DE0001, 16'hFFFF);
    tick();
    tests_run++;
    if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL bubble_beat: valid=%b ctrl=%h want 1/ffff", bus.out_valid, bus.out_ctrl);
    end
    // Junk on the data/ctrl lines with in_valid low must never show up.
    drive(1'b0, 32'hDEADBEEF, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      tick();
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 16'h0000 || bus.out_data !== '0) begin
        tests_failed++;
        $display("FAIL bubble_cycle%0d: valid=%b ctrl=%h data=%h want 0/0/0", k, bus.out_valid, bus.out_ctrl, bus.out_data);
      end
    end
    drive(1'b0, '0, '0);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL bubble_queue: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hE1, 16'h00E1);
    tick();
    drive(1'b0, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      tests_run++;
      if (bus.stall_cnt !== CNT_W'((k < 15) ? k : 15)) begin
        tests_failed++;
        $display("FAIL sat_cnt_k%0d: got %0d want %0d", k, bus.stall_cnt, (k < 15) ? k : 15);
      end
    end
    tests_run++; if (bus.occupancy !== 2'd1 || bus.out_data !== 32'hE1) begin tests_failed++; $display("FAIL sat_held: occ=%0d data=%h want 1/e1", bus.occupancy, bus.out_data); end
    do_reset();
    tests_run++; if (bus.stall_cnt !== '0) begin tests_failed++; $display("FAIL sat_reset: got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick();
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hF1, 16'h00F1);
    tick();
    drive(1'b1, 32'hF2, 16'h00F2);
    tick();
    drive(1'b0, '0, '0);
    tests_run++; if (bus.occupancy !== 2'd2) begin tests_failed++; $display("FAIL areset_pre_occ: got %0d want 2", bus.occupancy); end
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    tests_run++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_ctrl !== '0) begin tests_failed++; $display("FAIL areset_out: valid=%b data=%h ctrl=%h want 0", bus.out_valid, bus.out_data, bus.out_ctrl); end
    tests_run++; if (bus.in_ready !== 1'b1 || bus.occupancy !== 2'd0) begin tests_failed++; $display("FAIL areset_state: in_ready=%b occ=%0d want 1/0", bus.in_ready, bus.occupancy); end
    tests_run++; if (bus.stall_cnt !== '0) begin tests_failed++; $display("FAIL areset_stall: got %0d want 0", bus.stall_cnt); end
    rst = 1'b1;
    tick();
    bus.out_ready = 1'b1;
    drive(1'b1, 32'hF3, 16'h00F3);
    tick();
    drive(1'b0, '0, '0);
    tests_run++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hF3) begin tests_failed++; $display("FAIL areset_first_beat: valid=%b data=%h want 1/f3", bus.out_valid, bus.out_data); end
    tick();
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL areset_queue: %0d beats left want 0", exp_q.size()); end
  endtask

  task automatic test_random_traffic();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      tick();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) drive(1'b1, DATA_W'($urandom), CTRL_W'($urandom_range(1, 16'hFFFF)));
      else drive(1'b0, '0, '0);
      tests_run++;
      if (bus.occupancy == 2'd2 && bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rand_ready_full: in_ready=%b with occ=2", bus.in_ready); end
    end
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_drain: %0d beats left want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0);
    test_reset();
    test_stream();
    test_skid_fill();
    test_flush_full();
    test_bubble();
    test_saturation();
    test_async_reset();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
